// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_sb
// Purpose  : NRD-read / NWR-write register file with per-register pending
//            (busy) scoreboard. Optional same-cycle write bypass: REGFILE_BYPASS_EN
// Revision : 1.0
// ============================================================================
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  input  logic                flush_i,
  output logic [NREGS-1:0]    busy_vec_o,
  output logic                wr_conflict_o
);

  // A "live" address is in range and not the hardwired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (32'(a) < 32'(NREGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic             conflict_q, conflict_d;
  logic [NWR-1:0]   w_wr_live;
  logic             w_iss_live;

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      w_wr_live[j] = wr_en_i[j] && addr_live(wr_addr_i[j*AW +: AW]);
    end
    w_iss_live = iss_en_i && addr_live(iss_addr_i);
  end

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int j = 0; j < NWR; j++) begin
      if (w_wr_live[j]) begin
        regs_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
      end
    end
  end

  // Priority (lowest applied first): writeback clear, issue set, flush.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NWR; j++) begin
      if (w_wr_live[j]) begin
        pend_d[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
    end
    if (w_iss_live) begin
      pend_d[iss_addr_i] = 1'b1;
    end
    if (flush_i) begin
      pend_d = '0;
    end
    if (ZERO_REG != 0) begin
      pend_d[0] = 1'b0;
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_en_i[i] && wr_en_i[j] &&
            (wr_addr_i[i*AW +: AW] == wr_addr_i[j*AW +: AW])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      pend_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pend_q     <= pend_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy_vec_o    = pend_q;
  assign wr_conflict_o = conflict_q;

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_data;
      logic            w_busy;

      assign w_ra = rd_addr_i[k*AW +: AW];

      always_comb begin
        w_data = '0;
        w_busy = 1'b0;
        if (addr_live(w_ra)) begin
          w_data = regs_q[w_ra];
          w_busy = pend_q[w_ra];
        end
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (w_wr_live[j] && (wr_addr_i[j*AW +: AW] == w_ra)) begin
            w_data = wr_data_i[j*XLEN +: XLEN];
            if (!(w_iss_live && (iss_addr_i == w_ra))) begin
              w_busy = 1'b0;
            end
          end
        end
`endif
      end

      assign rd_data_o[k*XLEN +: XLEN] = w_data;
      assign rd_busy_o[k]              = w_busy;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp_sb
// Purpose  : Scoreboard bench for regfile_mp_sb (directed vectors).
// Revision : 1.0
// ============================================================================
module tb_regfile_mp_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NRD*AW-1:0]   rd_addr_i = '0;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic [NWR-1:0]      wr_en_i = '0;
  logic [NWR*AW-1:0]   wr_addr_i = '0;
  logic [NWR*XLEN-1:0] wr_data_i = '0;
  logic                iss_en_i = 1'b0;
  logic [AW-1:0]       iss_addr_i = '0;
  logic                flush_i = 1'b0;
  logic [NREGS-1:0]    busy_vec_o;
  logic                wr_conflict_o;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i), .flush_i(flush_i),
    .busy_vec_o(busy_vec_o), .wr_conflict_o(wr_conflict_o)
  );

  always #5 clk = ~clk;

  localparam int S_DATA = 0, S_BUSY = 1, S_VEC = 2, S_CONF = 3;
  typedef struct {
    string       name;
    int          sel;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_v(input string name, input int sel, input int port, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.port = port; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic rd(input int k, input int a);
    rd_addr_i[k*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int j, input int a, input logic [31:0] d);
    wr_en_i[j]                = 1'b1;
    wr_addr_i[j*AW +: AW]     = AW'(a);
    wr_data_i[j*XLEN +: XLEN] = d;
  endtask

  task automatic iss(input int a);
    iss_en_i   = 1'b1;
    iss_addr_i = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en_i  = '0;
    iss_en_i = 1'b0;
    flush_i  = 1'b0;
  endtask

  // Monitor: outputs are stable mid-cycle; drain every expectation queued this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        S_DATA:  act = rd_data_o[e.port*XLEN +: XLEN];
        S_BUSY:  act = {31'b0, rd_busy_o[e.port]};
        S_VEC:   act = busy_vec_o;
        default: act = {31'b0, wr_conflict_o};
      endcase
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_v("rst_vec", S_VEC, 0, 32'h0);
    expect_v("rst_conf", S_CONF, 0, 32'h0);
    tick();
    rst_n = 1'b1;

    for (int a = 0; a < NREGS; a++) begin
      rd(0, a); rd(1, NREGS - 1 - a);
      expect_v("init_data0", S_DATA, 0, 32'h0);
      expect_v("init_data1", S_DATA, 1, 32'h0);
      expect_v("init_busy0", S_BUSY, 0, 32'h0);
      expect_v("init_busy1", S_BUSY, 1, 32'h0);
      if (a == 0) begin
        expect_v("init_vec", S_VEC, 0, 32'h0);
        expect_v("init_conf", S_CONF, 0, 32'h0);
      end
      tick();
    end

    // x5 write; same-cycle read of x5 on port0
    wr(0, 5, 32'hDEADBEEF); rd(0, 5);
`ifdef REGFILE_BYPASS_EN
    expect_v("x5_samecyc", S_DATA, 0, 32'hDEADBEEF);
`else
    expect_v("x5_samecyc", S_DATA, 0, 32'h0);
`endif
    tick();
    rd(1, 5);
    expect_v("x5_read", S_DATA, 1, 32'hDEADBEEF);
    wr(0, 0, 32'h1234);
    tick();
    rd(0, 0);
    expect_v("x0_zero", S_DATA, 0, 32'h0);
    expect_v("x0_conf", S_CONF, 0, 32'h0);
    tick();

    // dual-port collision on x7
    wr(0, 7, 32'h11); wr(1, 7, 32'h22);
    tick();
    rd(0, 7);
    expect_v("x7_data", S_DATA, 0, 32'h22);
    expect_v("x7_conf1", S_CONF, 0, 32'h1);
    tick();
    expect_v("x7_conf0", S_CONF, 0, 32'h0);
    tick();

    // scoreboard: issue / writeback clear / issue wins
    iss(9);
    tick();
    rd(0, 9);
    expect_v("x9_vec_set", S_VEC, 0, 32'h0000_0200);
    expect_v("x9_busy", S_BUSY, 0, 32'h1);
    tick();
    wr(1, 9, 32'h99);
    tick();
    expect_v("x9_vec_clr", S_VEC, 0, 32'h0);
    expect_v("x9_busy_clr", S_BUSY, 0, 32'h0);
    expect_v("x9_data", S_DATA, 0, 32'h99);
    iss(9); wr(0, 9, 32'h77);
    tick();
    expect_v("x9_iss_wins", S_VEC, 0, 32'h0000_0200);
    expect_v("x9_data2", S_DATA, 0, 32'h77);
    tick();

    // flush beats same-cycle issue; x0 never busy
    iss(3);
    tick();
    iss(4);
    tick();
    expect_v("pre_flush_vec", S_VEC, 0, 32'h0000_0218);
    flush_i = 1'b1; iss(6);
    tick();
    rd(1, 6);
    expect_v("flush_vec", S_VEC, 0, 32'h0);
    expect_v("x6_busy", S_BUSY, 1, 32'h0);
    iss(0);
    tick();
    rd(0, 0);
    expect_v("x0_vec", S_VEC, 0, 32'h0);
    expect_v("x0_busy", S_BUSY, 0, 32'h0);
    tick();

    // same-cycle write/read of pending x10
    iss(10);
    tick();
    wr(0, 10, 32'hA5A5A5A5); rd(1, 10);
`ifdef REGFILE_BYPASS_EN
    expect_v("x10_byp_data", S_DATA, 1, 32'hA5A5A5A5);
    expect_v("x10_byp_busy", S_BUSY, 1, 32'h0);
`else
    expect_v("x10_old_data", S_DATA, 1, 32'h0);
    expect_v("x10_old_busy", S_BUSY, 1, 32'h1);
`endif
    tick();
    expect_v("x10_data", S_DATA, 1, 32'hA5A5A5A5);
    expect_v("x10_busy", S_BUSY, 1, 32'h0);
    expect_v("x10_vec", S_VEC, 0, 32'h0);
    tick();

    // async reset mid-cycle wipes data and pending bits
    iss(12); wr(0, 12, 32'hCC);
    tick();
    rd(0, 12);
    expect_v("x12_data", S_DATA, 0, 32'hCC);
    expect_v("x12_vec", S_VEC, 0, 32'h0000_1000);
    tick();
    rst_n = 1'b0;
    expect_v("arst_data", S_DATA, 0, 32'h0);
    expect_v("arst_vec", S_VEC, 0, 32'h0);
    expect_v("arst_x5", S_DATA, 1, 32'h0);
    rd(1, 5);
    tick();
    rst_n = 1'b1;
    tick();

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with an integrated per-register scoreboard, the next generation of the core's 2R/1W register file. It provides NRD combinational read ports and NWR synchronous write ports. Pending-write (busy) bits are set at issue and cleared at writeback. It sits between decode/issue (reads, issue marking) and the writeback stage(s), and feeds hazard/stall logic.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (2..64); AW = $clog2(NREGS) derived localparam
NRD, 2, number of read ports (1..4)
NWR, 2, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 is hardwired zero and is never busy

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
rd_addr_i  in  NRD*AW  read addresses, port k at [k*AW +: AW]
rd_data_o  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN], combinational
rd_busy_o  out  NRD  port k register has a pending write, combinational
wr_en_i  in  NWR  write enables
wr_addr_i  in  NWR*AW  write addresses, port j at [j*AW +: AW]
wr_data_i  in  NWR*XLEN  write data
iss_en_i  in  1  issue strobe: mark iss_addr_i pending
iss_addr_i  in  AW  destination register being issued
flush_i  in  1  clear all pending bits
busy_vec_o  out  NREGS  registered scoreboard vector
wr_conflict_o  out  1  registered one-cycle pulse: two enabled write ports hit the same address

Behaviour:
- Reset (async, asserts immediately): all regs = 0, all pending bits = 0, busy_vec_o = 0, wr_conflict_o = 0. Reset mid-operation discards in-flight writes and issues.
- Write: at posedge, each enabled port j with a valid address writes regs[addr] <= data. Same-address collision: the highest-index port wins. The next cycle wr_conflict_o = 1 for exactly one cycle, otherwise 0.
- Writes to address 0 are dropped when ZERO_REG=1. Addresses >= NREGS are dropped on write. On read they return 0 with busy 0.
- Read: rd_data_o[k] = regs[rd_addr_i[k]], zero-latency. Address 0 returns 0 when ZERO_REG=1. Any number of ports may read the same address.
- Scoreboard next-state per register r, in priority order:
  - flush_i: pending = 0 for all r. Same-cycle issue is ignored.
  - Issue to r (iss_en_i, iss_addr_i == r, r valid, not (ZERO_REG and r==0)): pending = 1. A same-cycle writeback to r does not clear it, because the new issue wins.
  - Any enabled write port to r: pending = 0.
  - Otherwise: hold.
- busy_vec_o is the registered pending vector; bit 0 is constant 0 when ZERO_REG=1.
- rd_busy_o[k] = pending[rd_addr_i[k]] (see optional feature for same-cycle effects). Invalid address gives 0.
- A write to a non-pending register is legal: data updates and pending stays 0.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: a read whose address matches an enabled, valid, same-cycle write port returns that port's wr_data_i, using the highest-index matching port. rd_busy_o[k] for that address is forced to 0 unless a same-cycle issue also targets it. ZERO_REG still forces 0.
- Not defined: reads return the pre-write array value. rd_busy_o reflects registered pending only. A same-cycle writer becomes visible the cycle after the posedge.

Test Plan:
- Reset then read all ports at addresses 0..NREGS-1 -> every rd_data_o = 0, busy_vec_o = 0, wr_conflict_o = 0.
- Port0 writes x5 = 0xDEADBEEF. Next cycle rd_addr port1 = 5 -> 0xDEADBEEF. A write of 0x1234 to x0 -> reading x0 still returns 0.
- Ports 0 and 1 both write x7 (0x11, 0x22) in the same cycle -> x7 = 0x22 and wr_conflict_o = 1 for exactly the following cycle.
- Issue x9 -> busy_vec_o[9] = 1 next cycle and rd_busy_o = 1 when reading x9. A write to x9 clears it. An issue of x9 in the same cycle as a write to x9 -> bit stays 1.
- Issue x3, x4, then flush_i together with issue x6 -> busy_vec_o = 0 next cycle, x6 not pending. An issue of x0 never sets bit 0.
- Same-cycle write x10 = 0xA5A5A5A5 with read x10 (x10 pending) -> with REGFILE_BYPASS_EN: data 0xA5A5A5A5, busy 0. Without it: old value, busy 1.
